ece571f23_g5_aes_inv_sub_bytes: RTL and testbench

- Sequential AES InvSubBytes engine for the decryption datapath.
- Accepts a 128-bit cipher state over a valid/ready handshake.
- Replaces every byte with its inverse S-box value, BYTES_PER_CYCLE bytes per clock, and returns the result over a valid/ready handshake.
- Its output is the inverse of the forward S-box used in encryption: inv(sbox(x)) == x for all 256 x.

---
 rtl/ece571f23_g5_aes_pkg.sv | 21 ++
 rtl/ece571f23_g5_aes_inv_sub_bytes_if.sv | 29 ++
 rtl/ece571f23_g5_aes_inv_sbox.sv | 55 +++++
 rtl/ece571f23_g5_aes_inv_sub_bytes.sv | 133 +++++++++++++
 tb/tb_ece571f23_g5_aes_inv_sub_bytes.sv | 270 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/ece571f23_g5_aes_pkg.sv
`default_nettype none
// ============================================================================
// Module   : ece571f23_g5_aes_pkg
// Brief    : Shared AES types and constants for the InvSubBytes engine.
// Revision : 1.0 - initial release
// ============================================================================
package ece571f23_g5_aes_pkg;

  localparam int AES_BYTES = 16;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } inv_sb_state_e;

endpackage
`default_nettype wire

// File: rtl/ece571f23_g5_aes_inv_sub_bytes_if.sv
`default_nettype none
// ============================================================================
// Module   : ece571f23_g5_aes_inv_sub_bytes_if
// Brief    : Input/output valid-ready bundle of the InvSubBytes engine.
// Revision : 1.0 - initial release
// ============================================================================
interface ece571f23_g5_aes_inv_sub_bytes_if;
  import ece571f23_g5_aes_pkg::*;

  logic   in_valid;
  logic   in_ready;
  state_t in_state;
  logic   out_valid;
  logic   out_ready;
  state_t out_state;

  // Engine side
  modport slave (
    input  in_valid, in_state, out_ready,
    output in_ready, out_valid, out_state
  );

  // Producer/consumer side
  modport master (
    output in_valid, in_state, out_ready,
    input  in_ready, out_valid, out_state
  );
endinterface
`default_nettype wire

// File: rtl/ece571f23_g5_aes_inv_sbox.sv
`default_nettype none
// ============================================================================
// Module   : ece571f23_g5_aes_inv_sbox
// Brief    : Combinational AES inverse S-box, one byte in, one byte out.
// Revision : 1.0 - initial release
// ============================================================================
module ece571f23_g5_aes_inv_sbox
  import ece571f23_g5_aes_pkg::*;
(
  input  byte_t i_byte,
  output byte_t o_byte
);

  // Full 256-entry table; the default arm exists only to keep X out
  always_comb begin
    o_byte = 8'h00;
    unique case (i_byte)
      8'h00: o_byte = 8'h52; 8'h01: o_byte = 8'h09; 8'h02: o_byte = 8'h6a; 8'h03: o_byte = 8'hd5; 8'h04: o_byte = 8'h30; 8'h05: o_byte = 8'h36; 8'h06: o_byte = 8'ha5; 8'h07: o_byte = 8'h38;
      8'h08: o_byte = 8'hbf; 8'h09: o_byte = 8'h40; 8'h0a: o_byte = 8'ha3; 8'h0b: o_byte = 8'h9e; 8'h0c: o_byte = 8'h81; 8'h0d: o_byte = 8'hf3; 8'h0e: o_byte = 8'hd7; 8'h0f: o_byte = 8'hfb;
      8'h10: o_byte = 8'h7c; 8'h11: o_byte = 8'he3; 8'h12: o_byte = 8'h39; 8'h13: o_byte = 8'h82; 8'h14: o_byte = 8'h9b; 8'h15: o_byte = 8'h2f; 8'h16: o_byte = 8'hff; 8'h17: o_byte = 8'h87;
      8'h18: o_byte = 8'h34; 8'h19: o_byte = 8'h8e; 8'h1a: o_byte = 8'h43; 8'h1b: o_byte = 8'h44; 8'h1c: o_byte = 8'hc4; 8'h1d: o_byte = 8'hde; 8'h1e: o_byte = 8'he9; 8'h1f: o_byte = 8'hcb;
      8'h20: o_byte = 8'h54; 8'h21: o_byte = 8'h7b; 8'h22: o_byte = 8'h94; 8'h23: o_byte = 8'h32; 8'h24: o_byte = 8'ha6; 8'h25: o_byte = 8'hc2; 8'h26: o_byte = 8'h23; 8'h27: o_byte = 8'h3d;
      8'h28: o_byte = 8'hee; 8'h29: o_byte = 8'h4c; 8'h2a: o_byte = 8'h95; 8'h2b: o_byte = 8'h0b; 8'h2c: o_byte = 8'h42; 8'h2d: o_byte = 8'hfa; 8'h2e: o_byte = 8'hc3; 8'h2f: o_byte = 8'h4e;
      8'h30: o_byte = 8'h08; 8'h31: o_byte = 8'h2e; 8'h32: o_byte = 8'ha1; 8'h33: o_byte = 8'h66; 8'h34: o_byte = 8'h28; 8'h35: o_byte = 8'hd9; 8'h36: o_byte = 8'h24; 8'h37: o_byte = 8'hb2;
      8'h38: o_byte = 8'h76; 8'h39: o_byte = 8'h5b; 8'h3a: o_byte = 8'ha2; 8'h3b: o_byte = 8'h49; 8'h3c: o_byte = 8'h6d; 8'h3d: o_byte = 8'h8b; 8'h3e: o_byte = 8'hd1; 8'h3f: o_byte = 8'h25;
      8'h40: o_byte = 8'h72; 8'h41: o_byte = 8'hf8; 8'h42: o_byte = 8'hf6; 8'h43: o_byte = 8'h64; 8'h44: o_byte = 8'h86; 8'h45: o_byte = 8'h68; 8'h46: o_byte = 8'h98; 8'h47: o_byte = 8'h16;
      8'h48: o_byte = 8'hd4; 8'h49: o_byte = 8'ha4; 8'h4a: o_byte = 8'h5c; 8'h4b: o_byte = 8'hcc; 8'h4c: o_byte = 8'h5d; 8'h4d: o_byte = 8'h65; 8'h4e: o_byte = 8'hb6; 8'h4f: o_byte = 8'h92;
      8'h50: o_byte = 8'h6c; 8'h51: o_byte = 8'h70; 8'h52: o_byte = 8'h48; 8'h53: o_byte = 8'h50; 8'h54: o_byte = 8'hfd; 8'h55: o_byte = 8'hed; 8'h56: o_byte = 8'hb9; 8'h57: o_byte = 8'hda;
      8'h58: o_byte = 8'h5e; 8'h59: o_byte = 8'h15; 8'h5a: o_byte = 8'h46; 8'h5b: o_byte = 8'h57; 8'h5c: o_byte = 8'ha7; 8'h5d: o_byte = 8'h8d; 8'h5e: o_byte = 8'h9d; 8'h5f: o_byte = 8'h84;
      8'h60: o_byte = 8'h90; 8'h61: o_byte = 8'hd8; 8'h62: o_byte = 8'hab; 8'h63: o_byte = 8'h00; 8'h64: o_byte = 8'h8c; 8'h65: o_byte = 8'hbc; 8'h66: o_byte = 8'hd3; 8'h67: o_byte = 8'h0a;
      8'h68: o_byte = 8'hf7; 8'h69: o_byte = 8'he4; 8'h6a: o_byte = 8'h58; 8'h6b: o_byte = 8'h05; 8'h6c: o_byte = 8'hb8; 8'h6d: o_byte = 8'hb3; 8'h6e: o_byte = 8'h45; 8'h6f: o_byte = 8'h06;
      8'h70: o_byte = 8'hd0; 8'h71: o_byte = 8'h2c; 8'h72: o_byte = 8'h1e; 8'h73: o_byte = 8'h8f; 8'h74: o_byte = 8'hca; 8'h75: o_byte = 8'h3f; 8'h76: o_byte = 8'h0f; 8'h77: o_byte = 8'h02;
      8'h78: o_byte = 8'hc1; 8'h79: o_byte = 8'haf; 8'h7a: o_byte = 8'hbd; 8'h7b: o_byte = 8'h03; 8'h7c: o_byte = 8'h01; 8'h7d: o_byte = 8'h13; 8'h7e: o_byte = 8'h8a; 8'h7f: o_byte = 8'h6b;
      8'h80: o_byte = 8'h3a; 8'h81: o_byte = 8'h91; 8'h82: o_byte = 8'h11; 8'h83: o_byte = 8'h41; 8'h84: o_byte = 8'h4f; 8'h85: o_byte = 8'h67; 8'h86: o_byte = 8'hdc; 8'h87: o_byte = 8'hea;
      8'h88: o_byte = 8'h97; 8'h89: o_byte = 8'hf2; 8'h8a: o_byte = 8'hcf; 8'h8b: o_byte = 8'hce; 8'h8c: o_byte = 8'hf0; 8'h8d: o_byte = 8'hb4; 8'h8e: o_byte = 8'he6; 8'h8f: o_byte = 8'h73;
      8'h90: o_byte = 8'h96; 8'h91: o_byte = 8'hac; 8'h92: o_byte = 8'h74; 8'h93: o_byte = 8'h22; 8'h94: o_byte = 8'he7; 8'h95: o_byte = 8'had; 8'h96: o_byte = 8'h35; 8'h97: o_byte = 8'h85;
      8'h98: o_byte = 8'he2; 8'h99: o_byte = 8'hf9; 8'h9a: o_byte = 8'h37; 8'h9b: o_byte = 8'he8; 8'h9c: o_byte = 8'h1c; 8'h9d: o_byte = 8'h75; 8'h9e: o_byte = 8'hdf; 8'h9f: o_byte = 8'h6e;
      8'ha0: o_byte = 8'h47; 8'ha1: o_byte = 8'hf1; 8'ha2: o_byte = 8'h1a; 8'ha3: o_byte = 8'h71; 8'ha4: o_byte = 8'h1d; 8'ha5: o_byte = 8'h29; 8'ha6: o_byte = 8'hc5; 8'ha7: o_byte = 8'h89;
      8'ha8: o_byte = 8'h6f; 8'ha9: o_byte = 8'hb7; 8'haa: o_byte = 8'h62; 8'hab: o_byte = 8'h0e; 8'hac: o_byte = 8'haa; 8'had: o_byte = 8'h18; 8'hae: o_byte = 8'hbe; 8'haf: o_byte = 8'h1b;
      8'hb0: o_byte = 8'hfc; 8'hb1: o_byte = 8'h56; 8'hb2: o_byte = 8'h3e; 8'hb3: o_byte = 8'h4b; 8'hb4: o_byte = 8'hc6; 8'hb5: o_byte = 8'hd2; 8'hb6: o_byte = 8'h79; 8'hb7: o_byte = 8'h20;
      8'hb8: o_byte = 8'h9a; 8'hb9: o_byte = 8'hdb; 8'hba: o_byte = 8'hc0; 8'hbb: o_byte = 8'hfe; 8'hbc: o_byte = 8'h78; 8'hbd: o_byte = 8'hcd; 8'hbe: o_byte = 8'h5a; 8'hbf: o_byte = 8'hf4;
      8'hc0: o_byte = 8'h1f; 8'hc1: o_byte = 8'hdd; 8'hc2: o_byte = 8'ha8; 8'hc3: o_byte = 8'h33; 8'hc4: o_byte = 8'h88; 8'hc5: o_byte = 8'h07; 8'hc6: o_byte = 8'hc7; 8'hc7: o_byte = 8'h31;
      8'hc8: o_byte = 8'hb1; 8'hc9: o_byte = 8'h12; 8'hca: o_byte = 8'h10; 8'hcb: o_byte = 8'h59; 8'hcc: o_byte = 8'h27; 8'hcd: o_byte = 8'h80; 8'hce: o_byte = 8'hec; 8'hcf: o_byte = 8'h5f;
      8'hd0: o_byte = 8'h60; 8'hd1: o_byte = 8'h51; 8'hd2: o_byte = 8'h7f; 8'hd3: o_byte = 8'ha9; 8'hd4: o_byte = 8'h19; 8'hd5: o_byte = 8'hb5; 8'hd6: o_byte = 8'h4a; 8'hd7: o_byte = 8'h0d;
      8'hd8: o_byte = 8'h2d; 8'hd9: o_byte = 8'he5; 8'hda: o_byte = 8'h7a; 8'hdb: o_byte = 8'h9f; 8'hdc: o_byte = 8'h93; 8'hdd: o_byte = 8'hc9; 8'hde: o_byte = 8'h9c; 8'hdf: o_byte = 8'hef;
      8'he0: o_byte = 8'ha0; 8'he1: o_byte = 8'he0; 8'he2: o_byte = 8'h3b; 8'he3: o_byte = 8'h4d; 8'he4: o_byte = 8'hae; 8'he5: o_byte = 8'h2a; 8'he6: o_byte = 8'hf5; 8'he7: o_byte = 8'hb0;
      8'he8: o_byte = 8'hc8; 8'he9: o_byte = 8'heb; 8'hea: o_byte = 8'hbb; 8'heb: o_byte = 8'h3c; 8'hec: o_byte = 8'h83; 8'hed: o_byte = 8'h53; 8'hee: o_byte = 8'h99; 8'hef: o_byte = 8'h61;
      8'hf0: o_byte = 8'h17; 8'hf1: o_byte = 8'h2b; 8'hf2: o_byte = 8'h04; 8'hf3: o_byte = 8'h7e; 8'hf4: o_byte = 8'hba; 8'hf5: o_byte = 8'h77; 8'hf6: o_byte = 8'hd6; 8'hf7: o_byte = 8'h26;
      8'hf8: o_byte = 8'he1; 8'hf9: o_byte = 8'h69; 8'hfa: o_byte = 8'h14; 8'hfb: o_byte = 8'h63; 8'hfc: o_byte = 8'h55; 8'hfd: o_byte = 8'h21; 8'hfe: o_byte = 8'h0c; 8'hff: o_byte = 8'h7d;
      default: o_byte = 8'h00;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/ece571f23_g5_aes_inv_sub_bytes.sv
`default_nettype none
// ============================================================================
// Module   : ece571f23_g5_aes_inv_sub_bytes
// Brief    : Sequential AES InvSubBytes engine, BYTES_PER_CYCLE lookups per
//            clock, valid/ready in and out, back-to-back capable from DONE.
// Revision : 1.0 - initial release
// ============================================================================
module ece571f23_g5_aes_inv_sub_bytes
  import ece571f23_g5_aes_pkg::*;
#(
  parameter int BYTES_PER_CYCLE = 4
) (
  input  logic                            clk,
  input  logic                            rst_n,
  ece571f23_g5_aes_inv_sub_bytes_if.slave bus,
  output logic                            busy
);

  localparam int NGROUPS = AES_BYTES / BYTES_PER_CYCLE;
  localparam int CNT_W   = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CNT_W-1:0] LAST_GRP = CNT_W'(NGROUPS - 1);

  if (!(BYTES_PER_CYCLE == 1 || BYTES_PER_CYCLE == 2 || BYTES_PER_CYCLE == 4 ||
        BYTES_PER_CYCLE == 8 || BYTES_PER_CYCLE == 16)) begin : g_bad_bpc
    $error("BYTES_PER_CYCLE must be one of 1, 2, 4, 8, 16");
  end

  inv_sb_state_e    state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  state_t           work_q, work_d;

  byte_t      work_bytes [AES_BYTES];
  byte_t      next_bytes [AES_BYTES];
  logic [3:0] lane_idx   [BYTES_PER_CYCLE];
  byte_t      lane_in    [BYTES_PER_CYCLE];
  byte_t      lane_out   [BYTES_PER_CYCLE];

  // View the working register as bytes (byte 0 = MSB) and route the current group to the lanes
  always_comb begin
    for (int b = 0; b < AES_BYTES; b++) begin
      work_bytes[b] = work_q[127-8*b -: 8];
    end
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      lane_idx[g] = 4'(int'(cnt_q) * BYTES_PER_CYCLE + g);
      lane_in[g]  = work_bytes[lane_idx[g]];
    end
  end

  for (genvar g = 0; g < BYTES_PER_CYCLE; g++) begin : g_lane
    ece571f23_g5_aes_inv_sbox u_inv_sbox (
      .i_byte (lane_in[g]),
      .o_byte (lane_out[g])
    );
  end

  // State, group counter and working register; reset discards any partial result
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      work_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      work_q  <= work_d;
    end
  end

  // Next state: capture on accept, substitute one group per RUN cycle
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    for (int b = 0; b < AES_BYTES; b++) begin
      next_bytes[b] = work_bytes[b];
    end
    for (int g = 0; g < BYTES_PER_CYCLE; g++) begin
      next_bytes[lane_idx[g]] = lane_out[g];
    end
    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = RUN;
          cnt_d   = '0;
          work_d  = bus.in_state;
        end
      end
      RUN: begin
        for (int b = 0; b < AES_BYTES; b++) begin
          work_d[127-8*b -: 8] = next_bytes[b];
        end
        if (cnt_q == LAST_GRP) begin
          state_d = DONE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          if (bus.in_valid) begin
            state_d = RUN;
            cnt_d   = '0;
            work_d  = bus.in_state;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Handshake outputs; in DONE a new block is taken only when the result leaves
  always_comb begin
    bus.in_ready  = 1'b0;
    bus.out_valid = 1'b0;
    busy          = 1'b0;
    unique case (state_q)
      IDLE:    bus.in_ready = 1'b1;
      RUN:     busy = 1'b1;
      DONE: begin
        bus.out_valid = 1'b1;
        bus.in_ready  = bus.out_ready;
      end
      default: bus.in_ready = 1'b0;
    endcase
  end

  assign bus.out_state = work_q;

endmodule
`default_nettype wire

// File: tb/tb_ece571f23_g5_aes_inv_sub_bytes.sv
`default_nettype none
// ============================================================================
// Module   : tb_ece571f23_g5_aes_inv_sub_bytes
// Brief    : Directed bench; five engines (BPC 4,1,2,8,16) share clk/rst_n.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ece571f23_g5_aes_inv_sub_bytes;

  localparam int NDUT = 5;

  function automatic int bpc_of(input int k);
    case (k)
      0: return 4;
      1: return 1;
      2: return 2;
      3: return 8;
      default: return 16;
    endcase
  endfunction

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid  [NDUT];
  logic         out_ready [NDUT];
  logic [127:0] in_state  [NDUT];
  wire          in_ready  [NDUT];
  wire          out_valid [NDUT];
  wire          busy      [NDUT];
  wire  [127:0] out_state [NDUT];

  always #5 clk = ~clk;

  for (genvar k = 0; k < NDUT; k++) begin : g_dut
    localparam int BPC = bpc_of(k);
    ece571f23_g5_aes_inv_sub_bytes_if u_if ();
    assign u_if.in_valid  = in_valid[k];
    assign u_if.in_state  = in_state[k];
    assign u_if.out_ready = out_ready[k];
    assign in_ready[k]    = u_if.in_ready;
    assign out_valid[k]   = u_if.out_valid;
    assign out_state[k]   = u_if.out_state;
    ece571f23_g5_aes_inv_sub_bytes #(.BYTES_PER_CYCLE(BPC)) u_dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (u_if.slave),
      .busy  (busy[k])
    );
  end

  int n_cmp = 0;
  int n_bad = 0;

  logic [0:255][7:0] fwd;

  typedef struct {
    logic [7:0] b;
    logic [7:0] e;
  } vec_t;
  vec_t vecs [7];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] fwd_state(input logic [127:0] x);
    logic [127:0] r;
    for (int b = 0; b < 16; b++) r[127-8*b -: 8] = fwd[x[127-8*b -: 8]];
    return r;
  endfunction

  // One transaction on engine k from IDLE, checking latency and result, then drain
  task automatic run_one(input int k, input logic [127:0] din, input logic [127:0] dexp, input string name);
    int lat;
    check({name, " in_ready"}, 128'(in_ready[k]), 128'd1);
    in_valid[k] = 1'b1;
    in_state[k] = din;
    tick();
    in_valid[k] = 1'b0;
    lat = 1;
    while (!out_valid[k] && lat < 40) begin
      tick();
      lat++;
    end
    check({name, " latency"}, 128'(lat), 128'(16 / bpc_of(k) + 1));
    check({name, " data"}, out_state[k], dexp);
    tick();
  endtask

  logic [127:0] din, dexp, got [NDUT];
  int           lat [NDUT];
  logic [127:0] exp_q [$];
  logic [127:0] s_in [8];
  logic [127:0] s_exp [8];

  initial begin
    fwd = {128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
           128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
           128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
           128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
           128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
           128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
           128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
           128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};
    vecs[0] = '{8'h00, 8'h52}; vecs[1] = '{8'h52, 8'h48}; vecs[2] = '{8'h16, 8'hff};
    vecs[3] = '{8'hed, 8'h53}; vecs[4] = '{8'h63, 8'h00}; vecs[5] = '{8'h7d, 8'h13};
    vecs[6] = '{8'hff, 8'h7d};
    for (int k = 0; k < NDUT; k++) begin
      in_valid[k] = 1'b0; out_ready[k] = 1'b1; in_state[k] = '0;
    end

    // Reset state
    tick(); tick();
    for (int k = 0; k < NDUT; k++) begin
      check($sformatf("rst out_valid[%0d]", k), 128'(out_valid[k]), 128'd0);
      check($sformatf("rst busy[%0d]", k), 128'(busy[k]), 128'd0);
      check($sformatf("rst out_state[%0d]", k), out_state[k], 128'd0);
    end
    rst_n = 1'b1;
    tick();
    check("post-rst in_ready", 128'(in_ready[0]), 128'd1);

    // Basic vector
    run_one(0, 128'h637c777bf26b6fc53001672bfed7ab76, 128'h000102030405060708090a0b0c0d0e0f, "basic");

    // Single-byte boundary values at varying positions
    for (int i = 0; i < 7; i++) begin
      int p;
      p = 2 * i + 1;
      din = {16{8'h63}};
      dexp = '0;
      din[127-8*p -: 8] = vecs[i].b;
      dexp[127-8*p -: 8] = vecs[i].e;
      run_one(0, din, dexp, $sformatf("byte %h@%0d", vecs[i].b, p));
    end

    // Exhaustive round trip on every engine width in lockstep
    for (int x = 0; x < 256; x++) begin
      bit seen [NDUT];
      bit all_seen;
      int t;
      for (int k = 0; k < NDUT; k++) begin
        in_valid[k] = 1'b1;
        in_state[k] = {16{fwd[x]}};
        seen[k] = 1'b0; lat[k] = 0; got[k] = '0;
      end
      tick();
      for (int k = 0; k < NDUT; k++) in_valid[k] = 1'b0;
      t = 1;
      all_seen = 1'b0;
      while (t <= 20 && !all_seen) begin
        all_seen = 1'b1;
        for (int k = 0; k < NDUT; k++) begin
          if (!seen[k] && out_valid[k]) begin
            seen[k] = 1'b1; lat[k] = t; got[k] = out_state[k];
          end
          all_seen = all_seen & seen[k];
        end
        if (!all_seen) begin
          tick();
          t++;
        end
      end
      for (int k = 0; k < NDUT; k++) begin
        check($sformatf("rt x=%0d bpc=%0d lat", x, bpc_of(k)), 128'(lat[k]), 128'(16 / bpc_of(k) + 1));
        check($sformatf("rt x=%0d bpc=%0d data", x, bpc_of(k)), got[k], {16{x[7:0]}});
      end
      tick();
    end

    // Backpressure: hold DONE, in_valid asserted but must be ignored
    out_ready[0] = 1'b0;
    in_valid[0] = 1'b1;
    in_state[0] = 128'h637c777bf26b6fc53001672bfed7ab76;
    tick();
    in_valid[0] = 1'b0;
    for (int t = 0; t < 10 && !out_valid[0]; t++) tick();
    in_valid[0] = 1'b1;
    in_state[0] = {16{8'h7c}};
    for (int t = 0; t < 10; t++) begin
      check($sformatf("bp hold%0d out_valid", t), 128'(out_valid[0]), 128'd1);
      check($sformatf("bp hold%0d data", t), out_state[0], 128'h000102030405060708090a0b0c0d0e0f);
      check($sformatf("bp hold%0d in_ready", t), 128'(in_ready[0]), 128'd0);
      tick();
    end
    out_ready[0] = 1'b1;
    #1;
    check("bp release in_ready", 128'(in_ready[0]), 128'd1);
    tick();
    in_valid[0] = 1'b0;
    check("bp out_valid drop", 128'(out_valid[0]), 128'd0);
    begin
      int l;
      l = 1;
      while (!out_valid[0] && l < 40) begin
        tick();
        l++;
      end
      check("bp second latency", 128'(l), 128'd5);
      check("bp second data", out_state[0], {16{8'h01}});
    end
    tick();

    // Asynchronous reset during RUN cycle 2
    in_valid[0] = 1'b1;
    in_state[0] = 128'h637c777bf26b6fc53001672bfed7ab76;
    tick();
    in_valid[0] = 1'b0;
    tick();
    check("mid-run busy", 128'(busy[0]), 128'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async rst out_valid", 128'(out_valid[0]), 128'd0);
    check("async rst out_state", out_state[0], 128'd0);
    check("async rst busy", 128'(busy[0]), 128'd0);
    #2 rst_n = 1'b1;
    tick();
    check("after rst in_ready", 128'(in_ready[0]), 128'd1);
    run_one(0, {16{8'h7c}}, {16{8'h01}}, "after rst");

    // Back-to-back streaming against a scoreboard
    for (int i = 0; i < 8; i++) begin
      s_exp[i] = {$urandom, $urandom, $urandom, $urandom};
      s_in[i]  = fwd_state(s_exp[i]);
    end
    begin
      int idx, cyc, nout, last;
      bit acc;
      idx = 0; cyc = 0; nout = 0; last = -1;
      in_valid[0] = 1'b1;
      in_state[0] = s_in[0];
      while (nout < 8 && cyc < 200) begin
        if (out_valid[0]) begin
          if (exp_q.size() == 0) begin
            check($sformatf("stream extra out %0d", nout), out_state[0], 128'hx);
          end else begin
            check($sformatf("stream data %0d", nout), out_state[0], exp_q.pop_front());
          end
          if (last >= 0) check($sformatf("stream interval %0d", nout), 128'(cyc - last), 128'd5);
          last = cyc;
          nout++;
        end
        acc = in_valid[0] && in_ready[0];
        if (acc) exp_q.push_back(s_exp[idx]);
        tick();
        cyc++;
        if (acc) begin
          idx++;
          if (idx < 8) in_state[0] = s_in[idx];
          else in_valid[0] = 1'b0;
        end
      end
      check("stream count", 128'(nout), 128'd8);
      check("stream leftover", 128'(exp_q.size()), 128'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
